ltc2308_scan: RTL

Parametrised scanning driver for the LTC2308 8-channel 12-bit SPI ADC on the DE1-SoC, the successor to the fixed 8-channel round-robin driver. It adds a run-time channel mask, a programmable SCLK rate and conversion wait, and a single-ended/differential mode. It also emits a per-sample valid strobe with channel tag. It sits between the ADC pins and synth-side consumers such as control knobs and CV inputs, and keeps a register bank of the latest result per channel.

---
 rtl/ltc2308_scan_if.sv | 18 +
 rtl/ltc2308_scan.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ltc2308_scan_if.sv
// Per-sample result strobe from the LTC2308 scanner to its consumers.
interface ltc2308_scan_if;
  logic        sample_valid;
  logic [2:0]  sample_ch;
  logic [11:0] sample_data;

  modport master (
    output sample_valid,
    output sample_ch,
    output sample_data
  );

  modport slave (
    input sample_valid,
    input sample_ch,
    input sample_data
  );
endinterface

// File: rtl/ltc2308_scan.sv
// Masked round-robin scanner for the LTC2308 SPI ADC with a per-channel result bank.
module ltc2308_scan #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned CONV_CYCLES = 80,
  parameter int unsigned CONVST_HIGH = 2,
  parameter int unsigned SD          = 1,
  parameter int unsigned CODING      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [7:0]       ch_mask,
  output logic [7:0][11:0] data,
  ltc2308_scan_if.master   smp,
  output logic             busy,
  output logic             ADC_CONVST,
  output logic             ADC_SCLK,
  output logic             ADC_DIN,
  input  logic             ADC_DOUT
);

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned HALF_W     = 4;
  localparam int unsigned PHASE_W    = 5;
  localparam int unsigned PHASE_LAST = 23;
  localparam int unsigned WAIT_LAST  = CONV_CYCLES - CONVST_HIGH - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [HALF_W-1:0]    half_q, half_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [2:0]           ch_q, ch_d;
  logic [2:0]           prev_ch_q, prev_ch_d;
  logic                 prime_q, prime_d;
  logic [11:0]          shreg_q, shreg_d;
  logic [7:0][11:0]     data_q, data_d;
  logic                 convst_q, convst_d;
  logic                 sclk_q, sclk_d;
  logic                 din_q, din_d;
  logic                 valid_q, valid_d;
  logic [2:0]           sch_q, sch_d;
  logic [11:0]          sdata_q, sdata_d;
  logic                 busy_q, busy_d;
  logic [5:0]           cfg_c;
  logic [3:0]           bit_idx_c;

  // Lowest set bit of the mask.
  function automatic logic [2:0] first_ch(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Lowest set bit strictly above cur, wrapping to the lowest set bit.
  function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [7:0] m);
    logic [2:0] r;
    r = first_ch(m);
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) r = 3'(i);
    end
    return r;
  endfunction

  // Config word for the channel programmed in this frame: {SD, odd, sel1, sel0, UNI, SLP}.
  assign cfg_c = {1'(SD), ch_q[0], ch_q[2], ch_q[1], 1'(CODING), 1'b0};

  // Next-state, datapath and pin values; pins are registered from the next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    phase_d   = phase_q;
    ch_d      = ch_q;
    prev_ch_d = prev_ch_q;
    prime_d   = prime_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    sch_d     = sch_q;
    sdata_d   = sdata_q;
    convst_d  = 1'b0;
    sclk_d    = 1'b0;
    din_d     = 1'b0;
    busy_d    = 1'b0;
    bit_idx_c = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (enable && (ch_mask != 8'd0)) begin
          state_d = S_CONV;
          cnt_d   = '0;
          ch_d    = first_ch(ch_mask);
          prime_d = 1'b1;
        end
      end
      S_CONV: begin
        if (cnt_q == CNT_W'(CONVST_HIGH)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(WAIT_LAST)) begin
          state_d = S_SHIFT;
          half_d  = '0;
          phase_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (half_q == HALF_W'(CLK_DIV - 1)) begin
          half_d = '0;
          if (phase_q == PHASE_W'(PHASE_LAST)) begin
            state_d = S_DONE;
            // The priming frame shifts out a result nobody asked for.
            if (!prime_q) begin
              data_d[prev_ch_q] = shreg_q;
              valid_d           = 1'b1;
              sch_d             = prev_ch_q;
              sdata_d           = shreg_q;
            end
          end else begin
            phase_d = phase_q + PHASE_W'(1);
          end
        end else begin
          half_d = half_q + HALF_W'(1);
        end
      end
      S_DONE: begin
        prev_ch_d = ch_q;
        prime_d   = 1'b0;
        if (enable && (ch_mask != 8'd0)) begin
          state_d = S_CONV;
          cnt_d   = '0;
          ch_d    = next_ch(ch_q, ch_mask);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d != S_IDLE);
    convst_d = (state_d == S_CONV) && (cnt_d != '0);
    sclk_d   = (state_d == S_SHIFT) && phase_d[0];
    if (state_d == S_WAIT) begin
      din_d = cfg_c[5];
    end else if (state_d == S_SHIFT) begin
      bit_idx_c = phase_d[4:1];
      if (bit_idx_c < 4'd6) din_d = cfg_c[3'(4'd5 - bit_idx_c)];
    end

    // Capture DOUT on the edge that raises SCLK.
    if (sclk_d && !sclk_q) shreg_d = {shreg_q[10:0], ADC_DOUT};
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      half_q    <= '0;
      phase_q   <= '0;
      ch_q      <= '0;
      prev_ch_q <= '0;
      prime_q   <= 1'b0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sch_q     <= '0;
      sdata_q   <= '0;
      convst_q  <= 1'b0;
      sclk_q    <= 1'b0;
      din_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      phase_q   <= phase_d;
      ch_q      <= ch_d;
      prev_ch_q <= prev_ch_d;
      prime_q   <= prime_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sch_q     <= sch_d;
      sdata_q   <= sdata_d;
      convst_q  <= convst_d;
      sclk_q    <= sclk_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
    end
  end

  assign data             = data_q;
  assign smp.sample_valid = valid_q;
  assign smp.sample_ch    = sch_q;
  assign smp.sample_data  = sdata_q;
  assign busy             = busy_q;
  assign ADC_CONVST       = convst_q;
  assign ADC_SCLK         = sclk_q;
  assign ADC_DIN          = din_q;

endmodule
